serial_rx: RTL

- 8N1 asynchronous serial receiver; the receive-side counterpart of the SerialTx transmitter.
- Oversamples `serialIn` at `delay` clocks per bit and samples each bit mid-bit.
- Delivers bytes LSB-first into a one-entry holding register with a valid/ack handshake.
- Reports framing errors and overruns; sits between the external RX pin and the CPU's serial-port registers.

---
 rtl/serial_rx_if.sv | 21 ++
 rtl/serial_rx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_rx_if.sv
// Receiver bundle: serial line and acknowledge in, holding register and status out.
// The receiver uses the master side; the consumer (CPU registers, bench) uses slave.
interface serial_rx_if;
    logic       serialIn;
    logic [7:0] data;
    logic       dataValid;
    logic       dataAck;
    logic       frameError;
    logic       overrun;
    logic       busy;

    modport master (
        input  serialIn, dataAck,
        output data, dataValid, frameError, overrun, busy
    );

    modport slave (
        output serialIn, dataAck,
        input  data, dataValid, frameError, overrun, busy
    );
endinterface

// File: rtl/serial_rx.sv
// 8N1 asynchronous serial receiver: oversamples the line at delay clocks per bit,
// samples mid-bit, and delivers bytes into a one-entry holding register.
module serial_rx #(
    parameter int counterBits = 2,
    parameter int delay       = 3
) (
    input  logic        clk,
    input  logic        reset,
    serial_rx_if.master rx
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int half = (delay - 1) / 2;
    // IDLE has already spent one cycle on the first low sample, so START waits one less.
    localparam int start_wait = (half > 0) ? half - 1 : 0;
    localparam logic [counterBits-1:0] start_last = counterBits'(start_wait);
    localparam logic [counterBits-1:0] bit_last   = counterBits'(delay - 1);
    localparam logic [counterBits-1:0] cnt_one    = counterBits'(1);

    state_t                 state;
    state_t                 state_next;
    logic                   sync1;
    logic                   sync2;
    logic [counterBits-1:0] cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic [7:0]             data_q;
    logic                   valid_q;
    logic                   ovr_q;
    logic                   ferr_q;

    logic                   start_hit;
    logic                   bit_hit;
    logic                   cnt_clr;
    logic                   shift_en;
    logic                   stop_ok;
    logic                   stop_bad;
    logic                   load;
    logic                   set_ovr;

    assign start_hit = (cnt == start_last);
    assign bit_hit   = (cnt == bit_last);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking, so every flop sees pre-edge values whatever the statement order.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so no path through the case leaves it unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:      if (!sync2) state_next = START;
            START:     if (start_hit) state_next = sync2 ? IDLE : DATA;
            DATA:      if (bit_hit && bit_idx == 3'd7) state_next = STOP;
            STOP:      if (bit_hit) state_next = sync2 ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (sync2) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output and datapath-control logic.
    always_comb begin
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            IDLE, WAIT_HIGH: cnt_clr = 1'b1;
            START:           cnt_clr = start_hit;
            DATA: begin
                cnt_clr  = bit_hit;
                shift_en = bit_hit;
            end
            STOP: begin
                cnt_clr  = bit_hit;
                stop_ok  = bit_hit && sync2;
                stop_bad = bit_hit && !sync2;
            end
            default:         cnt_clr = 1'b1;
        endcase
    end

    // A good byte lands only if the register is free or being emptied this same cycle.
    assign load    = stop_ok && (!valid_q || rx.dataAck);
    assign set_ovr = stop_ok && valid_q && !rx.dataAck;

    // Synchronizer, bit timing and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            sync1 <= rx.serialIn;
            sync2 <= sync1;
            cnt   <= cnt_clr ? '0 : cnt + cnt_one;
            if (state == START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shreg <= {sync2, shreg[7:1]};
            end
        end
    end

    // Holding register and sticky status; a new set wins over a same-cycle ack clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (load) begin
                data_q <= shreg;
            end

            if (load) begin
                valid_q <= 1'b1;
            end else if (rx.dataAck) begin
                valid_q <= 1'b0;
            end

            if (set_ovr) begin
                ovr_q <= 1'b1;
            end else if (rx.dataAck) begin
                ovr_q <= 1'b0;
            end

            if (stop_bad) begin
                ferr_q <= 1'b1;
            end else if (rx.dataAck) begin
                ferr_q <= 1'b0;
            end
        end
    end

    assign rx.data       = data_q;
    assign rx.dataValid  = valid_q;
    assign rx.overrun    = ovr_q;
    assign rx.frameError = ferr_q;
    assign rx.busy       = (state != IDLE);
endmodule
